// File: rtl/ascensor_pkg.sv
// Shared constants, state encoding and request-mask helpers for the 4-floor elevator controller.
package ascensor_pkg;

    localparam int N_PISOS  = 4;
    localparam int CAB_BASE = 0;
    localparam int SUB_BASE = 4;
    localparam int BAJ_BASE = 7;
    localparam int EST_MOV  = 3;
    localparam int EST_DIR  = 2;

    typedef enum logic [1:0] {
        REPOSO   = 2'd0,
        MOVIENDO = 2'd1,
        PUERTAS  = 2'd2
    } estado_t;

    function automatic logic [9:0] bit_cab(input logic [1:0] f);
        return 10'b1 << (CAB_BASE + int'(f));
    endfunction

    // Hall bits that do not exist (up at the top floor, down at the ground floor) map to an empty mask.
    function automatic logic [9:0] bit_sub(input logic [1:0] f);
        return (f == 2'd3) ? 10'b0 : 10'b1 << (SUB_BASE + int'(f));
    endfunction

    function automatic logic [9:0] bit_baj(input logic [1:0] f);
        return (f == 2'd0) ? 10'b0 : 10'b1 << (BAJ_BASE + int'(f) - 1);
    endfunction

    function automatic logic [9:0] mascara_piso(input logic [1:0] f);
        return bit_cab(f) | bit_sub(f) | bit_baj(f);
    endfunction

    function automatic logic [N_PISOS-1:0] solicitudes(input logic [9:0] req);
        logic [N_PISOS-1:0] r;
        r = '0;
        for (int i = 0; i < N_PISOS; i++) begin
            r[i] = |(req & mascara_piso(2'(i)));
        end
        return r;
    endfunction

    function automatic logic por_encima(input logic [N_PISOS-1:0] req, input logic [1:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < N_PISOS; i++) begin
            if (i > int'(f)) r = r | req[i];
        end
        return r;
    endfunction

    function automatic logic por_debajo(input logic [N_PISOS-1:0] req, input logic [1:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < N_PISOS; i++) begin
            if (i < int'(f)) r = r | req[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/controlador_ascensor_temporizador.sv
// Loadable down-counter shared by travel and door timing; holds at zero once expired.
module temporizador_ascensor #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cargar,
    input  logic [W-1:0] valor_carga,
    output logic [W-1:0] valor,
    output logic         expira
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valor <= '0;
        end else if (cargar) begin
            valor <= valor_carga;
        end else if (valor != '0) begin
            valor <= valor - 1'b1;
        end
    end

    assign expira = (valor == '0);

endmodule

// File: rtl/controlador_ascensor.sv
// Elevator controller: request latching plus REPOSO/MOVIENDO/PUERTAS sequencing.
// Optional macro ASCENSOR_REABRIR_EN: a current-floor button during PUERTAS reopens the doors.
module controlador_ascensor
    import ascensor_pkg::*;
#(
    parameter int TRAVEL_CYCLES = 8,
    parameter int DOOR_CYCLES   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] botones,
    output logic [9:0] pisos,
    output logic [3:0] estado
);

    localparam int MAX_C = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int TW    = (MAX_C > 2) ? $clog2(MAX_C) : 1;
    localparam logic [TW-1:0] T_VIAJE  = TW'(TRAVEL_CYCLES - 1);
    localparam logic [TW-1:0] T_PUERTA = TW'(DOOR_CYCLES - 1);

    estado_t      st, st_next;
    logic [1:0]   piso, piso_next, nf;
    logic         dir, dir_next;
    logic [9:0]   pend, clear, eff, hall_dir, hall_op;
    logic [3:0]   req_p, req_e;
    logic         mas_lejos, parar, cargar, expira;
    logic [TW-1:0] valor_carga, cuenta_unused;

    temporizador_ascensor #(.W(TW)) u_temp (
        .clk         (clk),
        .rst_n       (rst_n),
        .cargar      (cargar),
        .valor_carga (valor_carga),
        .valor       (cuenta_unused),
        .expira      (expira)
    );

    assign eff   = pend | botones;
    assign req_p = solicitudes(pend);
    assign req_e = solicitudes(eff);

    // The stop decision uses pend|botones so a call for the floor being reached counts immediately.
    always_comb begin
        st_next     = st;
        piso_next   = piso;
        dir_next    = dir;
        clear       = '0;
        cargar      = 1'b0;
        valor_carga = '0;
        nf          = piso;
        mas_lejos   = 1'b0;
        parar       = 1'b0;
        hall_dir    = '0;
        hall_op     = '0;
        case (st)
            REPOSO: begin
                if (req_p[piso]) begin
                    st_next     = PUERTAS;
                    clear       = mascara_piso(piso);
                    cargar      = 1'b1;
                    valor_carga = T_PUERTA;
                end else if (por_encima(req_p, piso) && (dir || !por_debajo(req_p, piso))) begin
                    st_next     = MOVIENDO;
                    dir_next    = 1'b1;
                    cargar      = 1'b1;
                    valor_carga = T_VIAJE;
                end else if (por_debajo(req_p, piso)) begin
                    st_next     = MOVIENDO;
                    dir_next    = 1'b0;
                    cargar      = 1'b1;
                    valor_carga = T_VIAJE;
                end
            end
            MOVIENDO: begin
                if (expira) begin
                    nf        = dir ? piso + 2'd1 : piso - 2'd1;
                    piso_next = nf;
                    mas_lejos = dir ? por_encima(req_e, nf) : por_debajo(req_e, nf);
                    hall_dir  = dir ? bit_sub(nf) : bit_baj(nf);
                    hall_op   = dir ? bit_baj(nf) : bit_sub(nf);
                    parar     = (|(eff & (bit_cab(nf) | hall_dir))) | !mas_lejos;
                    cargar    = 1'b1;
                    if (parar) begin
                        st_next     = PUERTAS;
                        valor_carga = T_PUERTA;
                        clear       = bit_cab(nf) | hall_dir;
                        if (!mas_lejos) begin
                            clear    = clear | hall_op;
                            dir_next = !dir;
                        end
                    end else begin
                        valor_carga = T_VIAJE;
                    end
                end
            end
            PUERTAS: begin
`ifdef ASCENSOR_REABRIR_EN
                if (|(botones & mascara_piso(piso))) begin
                    cargar      = 1'b1;
                    valor_carga = T_PUERTA;
                    clear       = botones & mascara_piso(piso);
                end else if (expira) begin
                    st_next = REPOSO;
                end
`else
                if (expira) begin
                    st_next = REPOSO;
                end
`endif
            end
            default: st_next = REPOSO;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st   <= REPOSO;
            piso <= 2'd0;
            dir  <= 1'b0;
            pend <= '0;
        end else begin
            st   <= st_next;
            piso <= piso_next;
            dir  <= dir_next;
            pend <= (pend | botones) & ~clear;
        end
    end

    assign pisos            = pend;
    assign estado[EST_MOV]  = (st == MOVIENDO);
    assign estado[EST_DIR]  = dir;
    assign estado[1:0]      = piso;

endmodule

// File: tb/tb_controlador_ascensor.sv
// Directed bench for controlador_ascensor; expectations follow ASCENSOR_REABRIR_EN when defined.
module tb_controlador_ascensor;

    logic       clk;
    logic       rst_n;
    logic [9:0] botones;
    logic [9:0] pisos;
    logic [3:0] estado;

    int checks   = 0;
    int failures = 0;

`ifdef ASCENSOR_REABRIR_EN
    localparam bit REABRIR = 1'b1;
`else
    localparam bit REABRIR = 1'b0;
`endif
    localparam int DESFASE = REABRIR ? 2 : 0;

    typedef struct {
        logic [9:0] botones;
        int         ciclos;
        logic [9:0] pisos;
        logic [3:0] estado;
    } vector_t;

    vector_t tabla[37];

    controlador_ascensor #(.TRAVEL_CYCLES(8), .DOOR_CYCLES(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .botones (botones),
        .pisos   (pisos),
        .estado  (estado)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive b for one edge, then idle for the remaining cycles; returns 1 time unit after the last edge.
    task automatic applyStimulus(input logic [9:0] b, input int ciclos);
        botones = b;
        @(posedge clk);
        #1;
        botones = '0;
        for (int k = 1; k < ciclos; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string nombre, input logic [9:0] ep, input logic [3:0] ee);
        checks++;
        if (pisos !== ep) begin
            failures++;
            $display("[TB] FAIL %s pisos: got %h expected %h", nombre, pisos, ep);
        end
        checks++;
        if (estado !== ee) begin
            failures++;
            $display("[TB] FAIL %s estado: got %b expected %b", nombre, estado, ee);
        end
    endtask

    initial begin
        // single trip 0 -> 3, door dwell, return to 0
        tabla[0]  = '{10'h008, 1,  10'h008, 4'b0000};
        tabla[1]  = '{10'h000, 1,  10'h008, 4'b1100};
        tabla[2]  = '{10'h000, 7,  10'h008, 4'b1100};
        tabla[3]  = '{10'h000, 1,  10'h008, 4'b1101};
        tabla[4]  = '{10'h000, 7,  10'h008, 4'b1101};
        tabla[5]  = '{10'h000, 1,  10'h008, 4'b1110};
        tabla[6]  = '{10'h000, 8,  10'h000, 4'b0011};
        tabla[7]  = '{10'h001, 1,  10'h001, 4'b0011};
        tabla[8]  = '{10'h000, 3,  10'h001, 4'b0011};
        tabla[9]  = '{10'h000, 1,  10'h001, 4'b1011};
        tabla[10] = '{10'h000, 8,  10'h001, 4'b1010};
        tabla[11] = '{10'h000, 16, 10'h000, 4'b0100};
        // collective stop at floor 1 on the way up
        tabla[12] = '{10'h000, 4,  10'h000, 4'b0100};
        tabla[13] = '{10'h008, 1,  10'h008, 4'b0100};
        tabla[14] = '{10'h000, 1,  10'h008, 4'b1100};
        tabla[15] = '{10'h020, 1,  10'h028, 4'b1100};
        tabla[16] = '{10'h000, 7,  10'h008, 4'b0101};
        tabla[17] = '{10'h000, 4,  10'h008, 4'b0101};
        tabla[18] = '{10'h000, 1,  10'h008, 4'b1101};
        tabla[19] = '{10'h000, 16, 10'h000, 4'b0011};
        // back to floor 1 so dir ends up = 1, then direction preference
        tabla[20] = '{10'h000, 4,  10'h000, 4'b0011};
        tabla[21] = '{10'h002, 1,  10'h002, 4'b0011};
        tabla[22] = '{10'h000, 1,  10'h002, 4'b1011};
        tabla[23] = '{10'h000, 16, 10'h000, 4'b0101};
        tabla[24] = '{10'h000, 4,  10'h000, 4'b0101};
        tabla[25] = '{10'h009, 1,  10'h009, 4'b0101};
        tabla[26] = '{10'h000, 1,  10'h009, 4'b1101};
        tabla[27] = '{10'h000, 16, 10'h001, 4'b0011};
        tabla[28] = '{10'h000, 5,  10'h001, 4'b1011};
        tabla[29] = '{10'h000, 24, 10'h000, 4'b0100};
        // go to floor 2, then same-floor hall-down request
        tabla[30] = '{10'h000, 4,  10'h000, 4'b0100};
        tabla[31] = '{10'h004, 2,  10'h004, 4'b1100};
        tabla[32] = '{10'h000, 16, 10'h000, 4'b0010};
        tabla[33] = '{10'h000, 4,  10'h000, 4'b0010};
        tabla[34] = '{10'h100, 1,  10'h100, 4'b0010};
        tabla[35] = '{10'h000, 1,  10'h000, 4'b0010};
        tabla[36] = '{10'h000, 4,  10'h000, 4'b0010};

        rst_n   = 1'b0;
        botones = '0;
        #1;
        checkOutput("reset_inicial", 10'h000, 4'b0000);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("tras_reset", 10'h000, 4'b0000);

        for (int i = 0; i < 37; i++) begin
            applyStimulus(tabla[i].botones, tabla[i].ciclos);
            checkOutput($sformatf("vec%0d", i), tabla[i].pisos, tabla[i].estado);
        end

        // door reopen at floor 1
        applyStimulus(10'h002, 1);
        checkOutput("reabrir_pulso", 10'h002, 4'b0010);
        applyStimulus(10'h000, 1);
        checkOutput("reabrir_baja", 10'h002, 4'b1010);
        applyStimulus(10'h000, 8);
        checkOutput("reabrir_llega1", 10'h000, 4'b0101);
        applyStimulus(10'h000, 2);
        applyStimulus(10'h002, 1);
        checkOutput("reabrir_t1", REABRIR ? 10'h000 : 10'h002, 4'b0101);
        applyStimulus(10'h000, 1);
        checkOutput("reabrir_t2", REABRIR ? 10'h000 : 10'h002, 4'b0101);
        applyStimulus(10'h000, 1);
        checkOutput("reabrir_t3", 10'h000, 4'b0101);
        applyStimulus(10'h008, 1);
        applyStimulus(10'h000, 1);
        checkOutput("reabrir_t5", 10'h008, 4'b0101);
        applyStimulus(10'h000, 1);
        checkOutput("reabrir_t6", 10'h008, REABRIR ? 4'b1101 : 4'b0101);
        applyStimulus(10'h000, 1);
        checkOutput("reabrir_t7", 10'h008, REABRIR ? 4'b1101 : 4'b0101);
        applyStimulus(10'h000, 1);
        checkOutput("reabrir_t8", 10'h008, 4'b1101);

        // hall-up at floor 2 arriving in the same cycle the car reaches it
        applyStimulus(10'h000, 7 - DESFASE);
        applyStimulus(10'h040, 1);
        checkOutput("llegada_misma", 10'h008, 4'b0110);
        applyStimulus(10'h000, 5);
        checkOutput("sale_piso2", 10'h008, 4'b1110);
        applyStimulus(10'h000, 1);

        // asynchronous reset while moving away from floor 2
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("reset_async", 10'h000, 4'b0000);
        @(posedge clk);
        #1;
        checkOutput("reset_mantenido", 10'h000, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("reposo%0d", i), 10'h000, 4'b0000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
